// File: rtl/montacarga_call_scheduler.sv
// montacarga_call_scheduler: SCAN call scheduler for a 3-floor freight lift with dwell timing and latched fault.
// Floors are kept as index 0..2 internally; the display code is index+1.
module montacarga_call_scheduler #(
    parameter int DWELL_CYCLES   = 8000000,
    parameter int TRAVEL_TIMEOUT = 40000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] P,
    input  logic [2:0] FC,
    output logic [1:0] motor,
    output logic [1:0] visual,
    output logic       enable,
    output logic [2:0] pending,
    output logic       fault
);
    localparam int CMAX = DWELL_CYCLES > TRAVEL_TIMEOUT ? DWELL_CYCLES : TRAVEL_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DWELL, FAULT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      floor_q, floor_d;
    logic            dir_up_q, dir_up_d;
    logic [2:0]      pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      p_s1_q, p_s2_q, p_s3_q, fc_s1_q, fc_s2_q;

    logic [2:0] rise, set_m, clr_m, cur_oh, nxt_oh, opp_oh, above_m, below_m;
    logic [1:0] nxt;
    logic       up, above, below, multi_fc;

    always_comb begin
        rise     = p_s2_q & ~p_s3_q;
        cur_oh   = 3'b001 << floor_q;
        up       = state_q == MOVE_UP;
        nxt      = up ? floor_q + 2'd1 : floor_q - 2'd1;
        nxt_oh   = 3'b001 << nxt;
        // floor on the side the car is leaving; shifts out to zero at the end floors
        opp_oh   = up ? cur_oh >> 1 : cur_oh << 1;
        above_m  = ~(cur_oh | (cur_oh - 3'd1));
        below_m  = cur_oh - 3'd1;
        above    = |(pend_q & above_m);
        below    = |(pend_q & below_m);
        multi_fc = (fc_s2_q & (fc_s2_q - 3'd1)) != 3'd0;
        set_m    = (state_q == IDLE || state_q == DWELL) ? rise & ~cur_oh : rise;
        clr_m    = 3'd0;
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (multi_fc) state_d = FAULT;
                else if (above && (dir_up_q || !below)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(TRAVEL_TIMEOUT - 1) || multi_fc || |(fc_s2_q & opp_oh)) state_d = FAULT;
                else if (|(fc_s2_q & nxt_oh)) begin
                    floor_d = nxt;
                    cnt_d   = '0;
                    if (|(pend_q & nxt_oh) || nxt == (up ? 2'd2 : 2'd0)) begin
                        clr_m   = nxt_oh;
                        state_d = DWELL;
                    end
                end
            end
            DWELL: begin
                if (|(rise & cur_oh)) cnt_d = '0;
                else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CW'(1);
            end
            default: state_d = FAULT;
        endcase
        pend_d = state_d == FAULT ? 3'd0 : (pend_q | set_m) & ~clr_m;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            floor_q  <= 2'd0;
            dir_up_q <= 1'b1;
            pend_q   <= 3'd0;
            cnt_q    <= '0;
            p_s1_q   <= 3'd0;
            p_s2_q   <= 3'd0;
            p_s3_q   <= 3'd0;
            fc_s1_q  <= 3'd0;
            fc_s2_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_up_q <= dir_up_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            p_s1_q   <= P;
            p_s2_q   <= p_s1_q;
            p_s3_q   <= p_s2_q;
            fc_s1_q  <= FC;
            fc_s2_q  <= fc_s1_q;
        end
    end

    assign motor   = up ? 2'b01 : state_q == MOVE_DOWN ? 2'b10 : 2'b00;
    assign enable  = state_q == IDLE || state_q == DWELL;
    assign visual  = enable ? floor_q + 2'd1 : 2'd0;
    assign fault   = state_q == FAULT;
    assign pending = pend_q;
endmodule

// File: tb/tb_montacarga_call_scheduler.sv
// tb_montacarga_call_scheduler: randomized lift traffic against a floor-level reference model with a per-cycle scoreboard.
module tb_montacarga_call_scheduler;
    localparam int DW = 4, TT = 20;
    localparam int MI = 0, MU = 1, MD = 2, MW = 3, MF = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic [2:0] P = 3'd0, FC = 3'd0;
    logic [1:0] motor, visual;
    logic       enable, fault;
    logic [2:0] pending;

    montacarga_call_scheduler #(.DWELL_CYCLES(DW), .TRAVEL_TIMEOUT(TT)) dut (
        .clk(clk), .reset(reset), .P(P), .FC(FC),
        .motor(motor), .visual(visual), .enable(enable), .pending(pending), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] motor;
        logic [1:0] visual;
        logic       enable;
        logic [2:0] pending;
        logic       fault;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0, n_fail = 0;

    int       m_mode = MI, m_floor = 1, m_cnt = 0;
    bit       m_up = 1'b1;
    bit [2:0] m_pend = 3'd0;
    bit [2:0] ph[3];
    bit [2:0] fh[2];

    int env_key = -1, env_t = 0, env_d = 5, env_pulse = 0, env_pf = 1, flt = 0, p_hold = 0;
    bit [2:0] p_cur = 3'd0;

    // Calls reach the model two edges after the raw sample; limit switches likewise.
    task automatic model_step(input bit r, input bit [2:0] p, input bit [2:0] fc);
        bit [2:0] rise, fcs, pn;
        int nfc, nxt, opp, nm;
        bit ab, be;
        if (r) begin
            m_mode = MI; m_floor = 1; m_up = 1'b1; m_pend = 3'd0; m_cnt = 0;
            ph = '{3'd0, 3'd0, 3'd0};
            fh = '{3'd0, 3'd0};
            return;
        end
        rise = ph[1] & ~ph[2];
        fcs  = fh[1];
        nfc  = int'(fcs[0]) + int'(fcs[1]) + int'(fcs[2]);
        pn   = m_pend;
        for (int i = 0; i < 3; i++)
            if (rise[i] && !((m_mode == MI || m_mode == MW) && i == m_floor - 1)) pn[i] = 1'b1;
        nm = m_mode;
        if (m_mode == MI) begin
            ab = 1'b0; be = 1'b0;
            for (int f = 1; f <= 3; f++) begin
                if (f > m_floor && m_pend[f-1]) ab = 1'b1;
                if (f < m_floor && m_pend[f-1]) be = 1'b1;
            end
            m_cnt = 0;
            if (nfc > 1) nm = MF;
            else if (ab && (m_up || !be)) begin nm = MU; m_up = 1'b1; end
            else if (be) begin nm = MD; m_up = 1'b0; end
        end else if (m_mode == MU || m_mode == MD) begin
            nxt = m_floor + (m_mode == MU ? 1 : -1);
            opp = m_floor - (m_mode == MU ? 1 : -1);
            if (m_cnt + 1 == TT || nfc > 1 || (opp >= 1 && opp <= 3 && fcs[opp-1])) nm = MF;
            else if (fcs[nxt-1]) begin
                m_floor = nxt;
                m_cnt = 0;
                if (m_pend[nxt-1] || nxt == 1 || nxt == 3) begin
                    pn[nxt-1] = 1'b0;
                    nm = MW;
                end
            end else m_cnt++;
        end else if (m_mode == MW) begin
            if (rise[m_floor-1]) m_cnt = 0;
            else if (m_cnt + 1 == DW) begin nm = MI; m_cnt = 0; end
            else m_cnt++;
        end
        if (nm == MF) pn = 3'd0;
        m_mode = nm;
        m_pend = pn;
        ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = p;
        fh[1] = fh[0]; fh[0] = fc;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.motor   = m_mode == MU ? 2'b01 : m_mode == MD ? 2'b10 : 2'b00;
        o.enable  = m_mode == MI || m_mode == MW;
        o.visual  = o.enable ? 2'(m_floor) : 2'b00;
        o.pending = m_pend;
        o.fault   = m_mode == MF;
        return o;
    endfunction

    task automatic cyc(input bit r, input bit [2:0] p, input bit [2:0] fc);
        @(negedge clk);
        reset = r; P = p; FC = fc;
        @(posedge clk);
        model_step(r, p, fc);
        exp_q.push_back(model_obs());
    endtask

    // Physical car: after a random travel time the next floor's switch closes for 1-3 cycles.
    task automatic env_fc(input bit stall, output bit [2:0] f);
        int key;
        f = 3'd0;
        key = m_floor * 8 + m_mode;
        if (key != env_key) begin
            env_key = key; env_t = 0; env_d = $urandom_range(2, 24);
        end
        if (env_pulse > 0) begin
            f[env_pf-1] = 1'b1;
            env_pulse--;
        end else if ((m_mode == MU || m_mode == MD) && !stall) begin
            env_t++;
            if (env_t == env_d) begin
                env_pulse = $urandom_range(0, 2);
                env_pf = m_floor + (m_mode == MU ? 1 : -1);
                f[env_pf-1] = 1'b1;
            end
        end
    endtask

    task automatic run(input int n, input bit stall, input bit rnd);
        bit r;
        bit [2:0] p, fc;
        for (int i = 0; i < n; i++) begin
            r = 1'b0; p = 3'd0;
            env_fc(stall, fc);
            if (rnd) begin
                flt = m_mode == MF ? flt + 1 : 0;
                if (flt > 6 || $urandom_range(0, 299) == 0) r = 1'b1;
                if (p_hold > 0) p_hold--;
                else if ($urandom_range(0, 5) == 0) begin
                    p_cur = 3'($urandom); p_hold = $urandom_range(0, 3);
                end else p_cur = 3'd0;
                p = p_cur;
                if ($urandom_range(0, 249) == 0) fc = 3'($urandom);
            end
            cyc(r, p, fc);
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("motor", {2'b00, motor}, {2'b00, e.motor});
            chk("visual", {2'b00, visual}, {2'b00, e.visual});
            chk("enable", {3'b000, enable}, {3'b000, e.enable});
            chk("pending", {1'b0, pending}, {1'b0, e.pending});
            chk("fault", {3'b000, fault}, {3'b000, e.fault});
        end
    end

    initial begin
        cyc(1, 3'd0, 3'd0);
        cyc(1, 3'd0, 3'd0);
        cyc(0, 3'b100, 3'd0);
        cyc(0, 3'b100, 3'd0);
        run(70, 0, 0);
        cyc(0, 3'b001, 3'd0);
        run(6, 0, 0);
        cyc(0, 3'b011, 3'd0);
        run(90, 0, 0);
        cyc(1, 3'd0, 3'd0);
        cyc(0, 3'b010, 3'd0);
        run(30, 1, 0);
        cyc(0, 3'b111, 3'd0);
        run(6, 1, 0);
        cyc(1, 3'd0, 3'd0);
        cyc(0, 3'b100, 3'd0);
        run(8, 1, 0);
        cyc(0, 3'd0, 3'b011);
        run(6, 1, 0);
        cyc(1, 3'd0, 3'd0);
        cyc(0, 3'b100, 3'd0);
        run(8, 1, 0);
        cyc(1, 3'd0, 3'd0);
        run(4000, 0, 1);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
